// File: rtl/json_rx_pkg.sv
// Shared types and character codes for the JSON feedback receive path.
package json_rx_pkg;

  typedef enum logic [3:0] {
    IDLE, KEY_OPEN, KEY_CHAR, KEY_CLOSE, COLON, SIGN,
    INT, FRAC, AFTER_VAL, AWAIT_NL, SKIP
  } parse_state_t;

  localparam int MASK_T = 0;
  localparam int MASK_L = 1;
  localparam int MASK_R = 2;

  localparam int FRAC_DIGITS = 3;

  // Same codes as the command sender's character table
  localparam logic [7:0] _T            = 8'h54;
  localparam logic [7:0] _L            = 8'h4C;
  localparam logic [7:0] _R            = 8'h52;
  localparam logic [7:0] _COLON        = 8'h3A;
  localparam logic [7:0] _COMMA        = 8'h2C;
  localparam logic [7:0] _DOUBLE_QUOTE = 8'h22;
  localparam logic [7:0] _OPEN_BRACE   = 8'h7B;
  localparam logic [7:0] _CLOSE_BRACE  = 8'h7D;
  localparam logic [7:0] _PERIOD       = 8'h2E;
  localparam logic [7:0] _NEWLINE      = 8'h0A;
  localparam logic [7:0] _MINUS        = 8'h2D;
  localparam logic [7:0] _SPACE        = 8'h20;
  localparam logic [7:0] _TAB          = 8'h09;
  localparam logic [7:0] _CR           = 8'h0D;
  localparam logic [7:0] _ZERO         = 8'h30;
  localparam logic [7:0] _NINE         = 8'h39;

endpackage

// File: rtl/json_feedback_receiver_uart_rx.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling, LSB first, stop-bit check.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [BITS_N-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (BITS_N > 1) ? $clog2(BITS_N) : 1;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  rx_state_t         state, state_nxt;
  logic [1:0]        sync_q;
  logic              rx_s;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [BW-1:0]     bit_idx, bit_nxt;
  logic [BITS_N-1:0] shift, shift_nxt;
  logic              valid_nxt, err_nxt;

  assign rx_s    = sync_q[1];
  assign rx_data = shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], rx};
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
      rx_valid <= valid_nxt;
      rx_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      RX_IDLE: if (!rx_s) begin
        state_nxt = RX_START;
        cnt_nxt   = '0;
      end
      RX_START: begin
        // A start edge that is gone by mid-bit is treated as a glitch
        if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? RX_IDLE : RX_DATA;
        end else cnt_nxt = cnt + CW'(1);
      end
      RX_DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_nxt   = '0;
          shift_nxt = {rx_s, shift[BITS_N-1:1]};
          if (bit_idx == BW'(BITS_N - 1)) state_nxt = RX_STOP;
          else bit_nxt = bit_idx + BW'(1);
        end else cnt_nxt = cnt + CW'(1);
      end
      RX_STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_nxt = '0;
          if (rx_s) begin
            valid_nxt = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = RX_BREAK;
          end
        end else cnt_nxt = cnt + CW'(1);
      end
      RX_BREAK: if (rx_s) state_nxt = RX_IDLE;
      default: state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/json_feedback_receiver.sv
// Parses {"T":<int>,"L":<dec>,"R":<dec>}\n feedback frames from the driver board
// and commits T/L/R atomically to registered outputs.
module json_feedback_receiver
  import json_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
  parameter int BITS_N       = 8,
  parameter int MAX_LEN      = 64,
  parameter int T_W          = 16,
  parameter int VAL_W        = 25,
  parameter int INT_DIGITS   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_in,
  output logic [T_W-1:0]   t_val,
  output logic [VAL_W-1:0] left_milli,
  output logic [VAL_W-1:0] right_milli,
  output logic [2:0]       field_mask,
  output logic             frame_valid,
  output logic             frame_error,
  output logic             busy
);

  localparam int ACC_W = VAL_W;
  localparam int IC_W  = $clog2(INT_DIGITS + 1);
  localparam int BC_W  = $clog2(MAX_LEN + 1);

  // rx_valid / rx_err are single-cycle strobes; the parser accepts every byte
  // the cycle it is presented, so there is no ready/backpressure path.
  logic [BITS_N-1:0] rx_data;
  logic              rx_valid, rx_err;
  logic [7:0]        rx_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT), .BITS_N(BITS_N)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (uart_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  assign rx_byte = 8'(rx_data);

  parse_state_t      state, state_nxt;
  logic [ACC_W-1:0]  acc, acc_nxt, digit;
  logic [IC_W-1:0]   int_cnt, int_cnt_nxt;
  logic [1:0]        frac_cnt, frac_cnt_nxt;
  logic              neg, neg_nxt;
  logic [7:0]        key, key_nxt;
  logic [BC_W-1:0]   byte_cnt, byte_cnt_nxt;
  logic [T_W-1:0]    sh_t, sh_t_nxt;
  logic [VAL_W-1:0]  sh_l, sh_l_nxt, sh_r, sh_r_nxt, mag, val;
  logic [2:0]        sh_mask, sh_mask_nxt;
  logic              commit, discard, val_end;
  logic              is_ws, is_digit, is_term, t_over;
  parse_state_t      term_state;

  assign busy     = (state != IDLE);
  assign is_ws    = (rx_byte == _SPACE) || (rx_byte == _TAB) || (rx_byte == _CR);
  assign is_digit = (rx_byte >= _ZERO) && (rx_byte <= _NINE);
  assign is_term  = is_ws || (rx_byte == _COMMA) || (rx_byte == _CLOSE_BRACE);
  assign digit    = ACC_W'(rx_byte[3:0]);
  assign t_over   = (acc >> T_W) != '0;

  // The byte ending a value is handled as AFTER_VAL would handle it
  assign term_state = is_ws ? AFTER_VAL : (rx_byte == _COMMA) ? KEY_OPEN : AWAIT_NL;

  always_comb begin
    case (frac_cnt)
      2'd0:    mag = acc * VAL_W'(1000);
      2'd1:    mag = acc * VAL_W'(100);
      2'd2:    mag = acc * VAL_W'(10);
      default: mag = acc;
    endcase
  end

  assign val = neg ? -mag : mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      int_cnt     <= '0;
      frac_cnt    <= '0;
      neg         <= 1'b0;
      key         <= '0;
      byte_cnt    <= '0;
      sh_t        <= '0;
      sh_l        <= '0;
      sh_r        <= '0;
      sh_mask     <= '0;
      t_val       <= '0;
      left_milli  <= '0;
      right_milli <= '0;
      field_mask  <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      acc         <= acc_nxt;
      int_cnt     <= int_cnt_nxt;
      frac_cnt    <= frac_cnt_nxt;
      neg         <= neg_nxt;
      key         <= key_nxt;
      byte_cnt    <= byte_cnt_nxt;
      sh_t        <= sh_t_nxt;
      sh_l        <= sh_l_nxt;
      sh_r        <= sh_r_nxt;
      sh_mask     <= sh_mask_nxt;
      frame_valid <= commit;
      frame_error <= discard;
      if (commit) begin
        t_val       <= sh_t;
        left_milli  <= sh_l;
        right_milli <= sh_r;
        field_mask  <= sh_mask;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    int_cnt_nxt  = int_cnt;
    frac_cnt_nxt = frac_cnt;
    neg_nxt      = neg;
    key_nxt      = key;
    byte_cnt_nxt = byte_cnt;
    sh_t_nxt     = sh_t;
    sh_l_nxt     = sh_l;
    sh_r_nxt     = sh_r;
    sh_mask_nxt  = sh_mask;
    commit       = 1'b0;
    discard      = 1'b0;
    val_end      = 1'b0;
    if (rx_err) begin
      state_nxt = SKIP;
    end else if (rx_valid) begin
      if (rx_byte == _NEWLINE) begin
        if (state == AWAIT_NL) begin
          commit  = sh_mask[MASK_T];
          discard = !sh_mask[MASK_T];
        end else if (state != IDLE) begin
          discard = 1'b1;
        end
        state_nxt = IDLE;
      end else if (state == IDLE) begin
        if (rx_byte == _OPEN_BRACE) begin
          state_nxt    = KEY_OPEN;
          byte_cnt_nxt = BC_W'(1);
          sh_t_nxt     = '0;
          sh_l_nxt     = '0;
          sh_r_nxt     = '0;
          sh_mask_nxt  = '0;
        end
      end else if (state != SKIP) begin
        byte_cnt_nxt = byte_cnt + BC_W'(1);
        if (byte_cnt_nxt >= BC_W'(MAX_LEN)) begin
          state_nxt = SKIP;
        end else begin
          case (state)
            KEY_OPEN:  if (!is_ws) state_nxt = (rx_byte == _DOUBLE_QUOTE) ? KEY_CHAR : SKIP;
            KEY_CHAR:  if (!is_ws) begin
              if (rx_byte > _SPACE && rx_byte < 8'h7F) begin
                key_nxt   = rx_byte;
                state_nxt = KEY_CLOSE;
              end else state_nxt = SKIP;
            end
            KEY_CLOSE: if (!is_ws) state_nxt = (rx_byte == _DOUBLE_QUOTE) ? COLON : SKIP;
            COLON:     if (!is_ws) begin
              state_nxt    = (rx_byte == _COLON) ? SIGN : SKIP;
              acc_nxt      = '0;
              int_cnt_nxt  = '0;
              frac_cnt_nxt = '0;
              neg_nxt      = 1'b0;
            end
            SIGN:      if (!is_ws) begin
              if (rx_byte == _MINUS && key != _T) begin
                neg_nxt   = 1'b1;
                state_nxt = INT;
              end else if (is_digit) begin
                acc_nxt     = digit;
                int_cnt_nxt = IC_W'(1);
                state_nxt   = INT;
              end else state_nxt = SKIP;
            end
            INT: begin
              if (is_digit) begin
                if (int_cnt == IC_W'(INT_DIGITS)) state_nxt = SKIP;
                else begin
                  acc_nxt     = acc * ACC_W'(10) + digit;
                  int_cnt_nxt = int_cnt + IC_W'(1);
                end
              end else if (int_cnt == '0) state_nxt = SKIP;
              else if (rx_byte == _PERIOD) state_nxt = (key == _T) ? SKIP : FRAC;
              else if (is_term) val_end = 1'b1;
              else state_nxt = SKIP;
            end
            FRAC: begin
              if (is_digit) begin
                if (frac_cnt < 2'(FRAC_DIGITS)) begin
                  acc_nxt      = acc * ACC_W'(10) + digit;
                  frac_cnt_nxt = frac_cnt + 2'd1;
                end
              end else if (is_term) val_end = 1'b1;
              else state_nxt = SKIP;
            end
            AFTER_VAL: if (!is_ws) begin
              if (rx_byte == _COMMA) state_nxt = KEY_OPEN;
              else if (rx_byte == _CLOSE_BRACE) state_nxt = AWAIT_NL;
              else state_nxt = SKIP;
            end
            AWAIT_NL:  if (!is_ws) state_nxt = SKIP;
            default:   state_nxt = SKIP;
          endcase
          if (val_end) begin
            state_nxt = term_state;
            case (key)
              _T: if (t_over) state_nxt = SKIP;
                  else begin
                    sh_t_nxt            = T_W'(acc);
                    sh_mask_nxt[MASK_T] = 1'b1;
                  end
              _L: begin
                sh_l_nxt            = val;
                sh_mask_nxt[MASK_L] = 1'b1;
              end
              _R: begin
                sh_r_nxt            = val;
                sh_mask_nxt[MASK_R] = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_json_feedback_receiver.sv
// Scoreboard bench for json_feedback_receiver: frames are sent over the UART pin,
// expected commit/discard events are queued and checked by an independent monitor.
module tb_json_feedback_receiver;

  localparam int CPB   = 4;
  localparam int T_W   = 16;
  localparam int VAL_W = 25;
  localparam int EW    = 1 + 3 + T_W + 2 * VAL_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             uart_in = 1'b1;
  logic [T_W-1:0]   t_val;
  logic [VAL_W-1:0] left_milli, right_milli;
  logic [2:0]       field_mask;
  logic             frame_valid, frame_error, busy;

  json_feedback_receiver #(
    .CLKS_PER_BIT (CPB),
    .BITS_N       (8),
    .MAX_LEN      (64),
    .T_W          (T_W),
    .VAL_W        (VAL_W),
    .INT_DIGITS   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_in     (uart_in),
    .t_val       (t_val),
    .left_milli  (left_milli),
    .right_milli (right_milli),
    .field_mask  (field_mask),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  int nl_cyc = -100;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]    exp_q[$];
  int               total = 0;
  int               bad = 0;
  logic [T_W-1:0]   m_t = '0;
  logic [VAL_W-1:0] m_l = '0, m_r = '0;
  logic [2:0]       m_mask = '0;

  function automatic logic [EW-1:0] pack(input logic kind, input logic [2:0] m,
                                         input logic [T_W-1:0] t,
                                         input logic [VAL_W-1:0] l,
                                         input logic [VAL_W-1:0] r);
    return {kind, m, t, l, r};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, want);
    end
  endtask

  task automatic expect_valid(input logic [T_W-1:0] t, input logic [VAL_W-1:0] l,
                              input logic [VAL_W-1:0] r, input logic [2:0] m);
    m_t = t; m_l = l; m_r = r; m_mask = m;
    exp_q.push_back(pack(1'b1, m, t, l, r));
  endtask

  task automatic expect_error();
    exp_q.push_back(pack(1'b0, m_mask, m_t, m_l, m_r));
  endtask

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b, input logic bad_stop);
    uart_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_in = ~bad_stop;
    repeat (CPB) @(negedge clk);
    if (bad_stop) begin
      uart_in = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: pending=%0d required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] act_ev, want_ev;
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.rx_valid && dut.rx_data == 8'h0A) nl_cyc = cyc;
      if (frame_valid || frame_error) begin
        act_ev = pack(frame_valid, field_mask, t_val, left_milli, right_milli);
        total++;
        if (frame_valid && frame_error) begin
          bad++;
          $display("FAIL pulse_overlap: got valid=1 error=1 required one of them");
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse: got %h required no event", act_ev);
        end else begin
          want_ev = exp_q.pop_front();
          total--;
          check("frame_event", act_ev, want_ev);
        end
        check("commit_latency", EW'(cyc), EW'(nl_cyc + 1));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_outputs", pack(busy, field_mask, t_val, left_milli, right_milli), '0);

    expect_valid(16'd1, VAL_W'(500), VAL_W'(-250), 3'b111);
    send_str("{\"T\":1,\"L\":0.5,\"R\":-0.25}\n");
    wait_drain("frame_basic");

    expect_valid(16'd1001, VAL_W'(12000), VAL_W'(0), 3'b011);
    send_str("{ \"T\" : 1001 , \"X\":7, \"L\":12}");
    send_byte(8'h0D, 1'b0);
    send_str("\n");
    wait_drain("frame_spaces");

    expect_error();
    send_str("{\"T\":1,\"L\":ab}\n");
    wait_drain("frame_bad_value");

    expect_valid(16'd2, VAL_W'(0), VAL_W'(3000), 3'b101);
    send_str("{\"T\":2,\"R\":3}\n");
    wait_drain("frame_t_r");

    expect_error();
    send_str("{\"T\":1,\"L\":12345}\n");
    wait_drain("frame_too_many_digits");

    expect_error();
    send_str("{\"T\":1}");
    repeat (63) send_byte(8'h20, 1'b0);
    send_str("\n");
    wait_drain("frame_too_long");

    expect_valid(16'd1, VAL_W'(0), VAL_W'(0), 3'b001);
    send_str("{\"T\":1}");
    repeat (56) send_byte(8'h20, 1'b0);
    send_str("\n");
    wait_drain("frame_max_len");

    expect_error();
    send_str("{\"T\":");
    send_byte(8'h36, 1'b1);
    send_str(",\"L\":1}\n");
    wait_drain("frame_bad_stop");

    expect_error();
    send_str("{\"T\":-1}\n");
    wait_drain("frame_negative_t");

    send_str("{\"T\":4");
    @(negedge clk);
    check("busy_mid_frame", EW'(busy), EW'(1));
    rst_n = 1'b0;
    #1;
    check("reset_mid_frame", pack(busy, field_mask, t_val, left_milli, right_milli), '0);
    check("reset_pulses", EW'({frame_valid, frame_error}), EW'(0));
    m_t = '0; m_l = '0; m_r = '0; m_mask = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    expect_valid(16'd5, VAL_W'(0), VAL_W'(0), 3'b001);
    send_str("{\"T\":5}\n");
    wait_drain("frame_after_reset");

    expect_valid(16'd3, VAL_W'(123), VAL_W'(0), 3'b111);
    send_str("{\"T\":3,\"L\":0.12345,\"R\":-0}\n");
    wait_drain("frame_frac_trunc");

    expect_error();
    send_str("{\"L\":1}\n");
    wait_drain("frame_no_t");

    repeat (60) @(negedge clk);
    check("queue_empty", EW'(exp_q.size()), EW'(0));
    check("final_outputs", pack(1'b0, field_mask, t_val, left_milli, right_milli),
          pack(1'b0, 3'b111, 16'd3, VAL_W'(123), VAL_W'(0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/json_feedback_receiver.md
Name: json_feedback_receiver

Overview:
- Receive side of the UART/JSON link to the motor driver board. Takes the board's serial line and deserialises it into bytes.
- Parses newline-terminated feedback frames of the form {"T":<int>,"L":<dec>,"R":<dec>}.
- Commits the T, L and R values atomically to registered outputs.
- Complements the existing JSON command sender, sharing its baud and byte format, so the control FSM can act on board feedback.

Parameters:
- CLKS_PER_BIT, 50_000_000/115_200: clocks per UART bit.
- BITS_N, 8: data bits per UART character.
- MAX_LEN, 64: maximum bytes per frame, including the final '\n'.
- T_W, 16: width of the unsigned "T" value.
- VAL_W, 25: width of the signed L/R values, in thousandths (milli-units).
- INT_DIGITS, 4: maximum integer digits per value.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_in  in  1  serial line from the driver board; idles high.
- t_val  out  T_W  last committed "T".
- left_milli  out  VAL_W  last committed "L" × 1000, two's complement.
- right_milli  out  VAL_W  last committed "R" × 1000, two's complement.
- field_mask  out  3  keys present in the last committed frame: [0]=T, [1]=L, [2]=R.
- frame_valid  out  1  one-cycle pulse when a frame is committed.
- frame_error  out  1  one-cycle pulse when a frame is discarded.
- busy  out  1  high while the parser is inside a frame (state not IDLE).

Behaviour:
- Reset: all outputs are 0; parser returns to IDLE. Reset mid-frame discards the partial frame with no pulse.
- Byte source:
  - uart_rx delivers rx_data and a one-cycle rx_valid at the middle of the stop bit.
  - If the stop bit is sampled low, rx_err pulses instead of rx_valid.
  - The parser consumes at most one byte per clk.
- Whitespace: space, tab and CR are ignored in every state except INT and FRAC, where they terminate the value.
- States:
  - IDLE: '{' goes to KEY_OPEN; all other bytes, including '\n', are ignored.
  - KEY_OPEN: '"' goes to KEY_CHAR.
  - KEY_CHAR: latches any single printable character as the key, then goes to KEY_CLOSE.
  - KEY_CLOSE: '"' goes to COLON.
  - COLON: ':' goes to SIGN.
  - SIGN: '-' sets neg and goes to INT; a digit loads the accumulator and goes to INT.
  - INT: a digit computes acc = acc*10 + d; '.' goes to FRAC; ',' or '}' ends the value.
  - FRAC: the first 3 digits are accumulated and frac_cnt increments; later digits are ignored. ',' or '}' ends the value.
  - AFTER_VAL: ',' goes to KEY_OPEN; '}' goes to AWAIT_NL.
  - AWAIT_NL: '\n' commits the frame.
  - SKIP: every byte is discarded until '\n', which raises frame_error and returns to IDLE.
- Value end:
  - Magnitude is acc × 10^(3−frac_cnt), computed as a combinational case over ×1000, ×100, ×10 and ×1.
  - The result is negated if neg is set.
  - It is written to the shadow register for key T, L or R, and the matching shadow mask bit is set.
  - Values for any other key are parsed and dropped.
  - The terminating ',' or '}' is then processed exactly as AFTER_VAL would process it.
- T restrictions: T must be a non-negative integer. A '-' or '.' on T is an error; a value ≥ 2^T_W is an error.
- Error conditions, each moving the parser to SKIP:
  - an unexpected character in any state;
  - more than INT_DIGITS integer digits;
  - SIGN followed by a non-digit, and also a '-' directly followed by a non-digit;
  - a byte count reaching MAX_LEN without '\n';
  - rx_err.
- Errors reported by the '\n' check: '\n' arriving in any state other than IDLE, AWAIT_NL or SKIP pulses frame_error and returns to IDLE.
- Commit:
  - Happens the clk after the '\n' rx_valid.
  - Requires shadow_mask[0] (T present); otherwise frame_error pulses instead.
  - On commit, t_val, left_milli, right_milli and field_mask load from the shadow registers, and frame_valid pulses.
  - Missing L or R commits 0.
  - Shadow registers and the byte count clear on entry to KEY_OPEN from IDLE.
- Stability: outputs are never modified except at commit or reset. frame_valid and frame_error are never high together.
- Duplicate keys: the last value wins.

Decomposition:
- Package json_rx_pkg holds:
  - the parser state enum typedef;
  - the field_mask bit indices;
  - FRAC_DIGITS = 3;
  - the key character codes, reused from lcd_inst_pkg (_T, _L, _R, _COLON, _COMMA, _DOUBLE_QUOTE, _OPEN_BRACE, _CLOSE_BRACE, _PERIOD) plus 8'h0A.
- Sub-module uart_rx:
  - Parameters: CLKS_PER_BIT and BITS_N.
  - Function: 2-flop synchroniser, start-bit mid-sample check, LSB-first data, stop-bit check.
  - Outputs: rx_data, rx_valid and rx_err.

Test Plan (CLKS_PER_BIT = 4 in simulation):
- Send {"T":1,"L":0.5,"R":-0.25}\n → one frame_valid pulse one clk after the '\n' byte; t_val=1, left_milli=500, right_milli=−250, field_mask=3'b111.
- Send { "T" : 1001 , "X":7, "L":12}\r\n → t_val=1001, left_milli=12000, right_milli=0, field_mask=3'b011, frame_valid=1.
- Send {"T":1,"L":ab}\n then {"T":2,"R":3}\n → exactly one frame_error pulse with outputs unchanged; then t_val=2, right_milli=3000, field_mask=3'b101.
- Send "L":12345, a 70-byte line without '\n', and a frame with a bad stop bit → each produces exactly one frame_error when its '\n' arrives; no frame_valid.
- Assert rst_n low mid-frame after {"T":4 → outputs 0 and busy 0 immediately; the following frame {"T":5}\n gives t_val=5.
- Send {"T":3,"L":0.12345,"R":-0}\n → left_milli=123, right_milli=0; {"L":1}\n (no T) → frame_error.
